// File: rtl/data_memory_unit_pkg.sv
// Shared constants for the data memory: access size codes, FSM state encodings
// and the load-result mask helper.
package data_memory_unit_pkg;

  localparam int TYPE_W = 3;

  localparam logic [TYPE_W-1:0] BYTE_WORD     = 3'd0;
  localparam logic [TYPE_W-1:0] HALF_WORD     = 3'd1;
  localparam logic [TYPE_W-1:0] COMPLETE_WORD = 3'd2;

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Unknown size codes mask to zero, which gives the all-zero load result.
  function automatic logic [31:0] size_mask(input logic [TYPE_W-1:0] size);
    case (size)
      BYTE_WORD:     size_mask = 32'h0000_00FF;
      HALF_WORD:     size_mask = 32'h0000_FFFF;
      COMPLETE_WORD: size_mask = 32'hFFFF_FFFF;
      default:       size_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_unit_byte_lane_decoder.sv
// Combinational access decode: size code and byte offset to byte enables,
// right-shift amount for loads and the misalignment flag.
module byte_lane_decoder
  import data_memory_unit_pkg::*;
(
  input  logic [TYPE_W-1:0] i_word_size,
  input  logic [1:0]        i_offset,
  output logic [3:0]        o_byte_en,
  output logic [4:0]        o_shift,
  output logic              o_misaligned,
  output logic              o_size_valid
);

  always_comb begin
    o_byte_en    = 4'b0000;
    o_shift      = {i_offset, 3'b000};
    o_misaligned = 1'b0;
    o_size_valid = 1'b1;
    case (i_word_size)
      BYTE_WORD: o_byte_en = 4'b0001 << i_offset;
      HALF_WORD: begin
        if (i_offset[0]) o_misaligned = 1'b1;
        else             o_byte_en    = 4'b0011 << i_offset;
      end
      COMPLETE_WORD: begin
        if (i_offset != 2'b00) o_misaligned = 1'b1;
        else                   o_byte_en    = 4'b1111;
      end
      default: o_size_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// MEM-stage data memory: byte-lane stores, right-aligned zero-filled loads,
// post-reset clear sweep and a registered word-wide debug read port.
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int TYPE_SIZE = TYPE_W,
  parameter int ADDR_SIZE = 7
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic                 i_read,
  input  logic                 i_write,
  input  logic [TYPE_SIZE-1:0] i_word_size,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_write_data,
  output logic [DATA_SIZE-1:0] o_read_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_misaligned,
  input  logic                 i_debug_en,
  input  logic [ADDR_SIZE-3:0] i_debug_addr,
  output logic [DATA_SIZE-1:0] o_debug_data
);

  localparam int DEPTH = 2 ** (ADDR_SIZE - 2);
  localparam logic [ADDR_SIZE-3:0] LAST_IDX = '1;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [ADDR_SIZE-3:0] clr_cnt_q, clr_cnt_d;
  logic                 op_write_q, op_write_d;
  logic [TYPE_SIZE-1:0] size_q, size_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic                 acc_mis_q, acc_mis_d;
  logic [DATA_SIZE-1:0] read_data_q, read_data_d;
  logic                 done_q, done_d;
  logic                 mis_out_q, mis_out_d;
  logic [DATA_SIZE-1:0] debug_q, debug_d;

  logic [3:0]           dec_byte_en;
  logic [4:0]           dec_shift;
  logic                 dec_misaligned;
  logic                 dec_size_valid;
  logic [ADDR_SIZE-3:0] word_idx;
  logic [DATA_SIZE-1:0] lane_data;

  assign word_idx = addr_q[ADDR_SIZE-1:2];

  byte_lane_decoder u_decoder (
    .i_word_size  (size_q),
    .i_offset     (addr_q[1:0]),
    .o_byte_en    (dec_byte_en),
    .o_shift      (dec_shift),
    .o_misaligned (dec_misaligned),
    .o_size_valid (dec_size_valid)
  );

  // Sub-word store data is replicated across lanes; the byte enables pick the lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_data[gi*8 +: 8] = (size_q == BYTE_WORD) ? wdata_q[7:0] :
                                  (size_q == HALF_WORD) ? wdata_q[(gi%2)*8 +: 8] :
                                                          wdata_q[gi*8 +: 8];
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    op_write_d  = op_write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    acc_mis_d   = acc_mis_q;
    read_data_d = read_data_q;
    debug_d     = debug_q;
    done_d      = 1'b0;
    mis_out_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_req && (i_read || i_write)) begin
          op_write_d = i_write;
          size_d     = i_word_size;
          addr_d     = i_addr;
          wdata_d    = i_write_data;
          state_d    = ST_ACCESS;
        end else if (i_debug_en && !i_req) begin
          debug_d = mem[i_debug_addr];
        end
      end
      ST_ACCESS: begin
        acc_mis_d = dec_misaligned;
        if (!op_write_q) begin
          if (dec_misaligned || !dec_size_valid) read_data_d = '0;
          else read_data_d = (mem[word_idx] >> dec_shift) & size_mask(size_q);
        end
        state_d = ST_RESP;
      end
      default: begin
        done_d    = 1'b1;
        mis_out_d = acc_mis_q;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      op_write_q  <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      acc_mis_q   <= 1'b0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      mis_out_q   <= 1'b0;
      debug_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      op_write_q  <= op_write_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      acc_mis_q   <= acc_mis_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
      mis_out_q   <= mis_out_d;
      debug_q     <= debug_d;
    end
  end

  // A reset landing on the ACCESS edge suppresses the pending store.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else if (state_q == ST_ACCESS && op_write_q) begin
        for (int l = 0; l < 4; l++) begin
          if (dec_byte_en[l]) mem[word_idx][l*8 +: 8] <= lane_data[l*8 +: 8];
        end
      end
    end
  end

  assign o_read_data  = read_data_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = done_q;
  assign o_misaligned = mis_out_q;
  assign o_debug_data = debug_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: a byte-addressed reference model predicts
// each completion; a monitor pops and compares whenever o_done is seen.
module tb_data_memory_unit;
  import data_memory_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, rd_en, wr_en, dbg_en;
  logic [2:0]  wsize;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata, dbg_data;
  logic        busy, done, mis;
  logic [4:0]  dbg_addr;

  always #5 clk = ~clk;

  data_memory_unit dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_read(rd_en), .i_write(wr_en),
    .i_word_size(wsize), .i_addr(addr), .i_write_data(wdata),
    .o_read_data(rdata), .o_busy(busy), .o_done(done), .o_misaligned(mis),
    .i_debug_en(dbg_en), .i_debug_addr(dbg_addr), .o_debug_data(dbg_data)
  );

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int unsigned acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  logic [7:0]  mem_m [128];
  logic [31:0] last_load;
  logic [31:0] dbg_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {mem_m[idx*4+3], mem_m[idx*4+2], mem_m[idx*4+1], mem_m[idx*4]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    last_load = 32'h0;
  endtask

  // Byte-addressed reference: n-byte access at a, little-endian, aligned to n.
  task automatic model_access(input logic w, input logic [2:0] sz, input int a,
                              input logic [31:0] d, output logic [31:0] r, output logic m);
    int n;
    logic [31:0] v;
    n = (sz == BYTE_WORD) ? 1 : (sz == HALF_WORD) ? 2 : (sz == COMPLETE_WORD) ? 4 : 0;
    m = (n != 0) && (a % n != 0);
    if (w) begin
      if (!m) for (int i = 0; i < n; i++) mem_m[a+i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      if (!m) for (int i = 0; i < n; i++) v = v | (32'(mem_m[a+i]) << (8*i));
      last_load = v;
    end
    r = last_load;
  endtask

  // Monitor: every o_done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("read_data", rdata, e.rd);
          chk("misaligned", 32'(mis), 32'(e.mis));
          chk("latency", cyc, e.acc + 2);
        end
      end else if (mis) begin
        chk("mis_without_done", 32'(mis), 32'h0);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'h0);
  endtask

  task automatic do_access(input logic w, input logic r, input logic [2:0] sz,
                           input logic [6:0] a, input logic [31:0] d, input logic de);
    exp_t e;
    logic [31:0] rv;
    logic mv;
    wait_idle();
    req = 1'b1; wr_en = w; rd_en = r; wsize = sz; addr = a; wdata = d;
    dbg_en = de; dbg_addr = 5'($urandom_range(0, 31));
    if (w || r) begin
      model_access(w, sz, int'(a), d, rv, mv);
      e.rd = rv; e.mis = mv; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req = 1'b0; wr_en = 1'b0; rd_en = 1'b0; dbg_en = 1'b0;
  endtask

  task automatic debug_read(input int idx);
    wait_idle();
    dbg_en = 1'b1; dbg_addr = 5'(idx);
    @(posedge clk);
    #1;
    dbg_en = 1'b0;
    @(negedge clk);
    dbg_last = model_word(idx);
    chk($sformatf("debug_word%0d", idx), dbg_data, dbg_last);
  endtask

  task automatic count_clear();
    int t = 0;
    while (busy && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("clear_busy_cycles", 32'(t), 32'd32);
  endtask

  initial begin
    int t;
    logic [2:0] sz;
    rst = 1'b1; req = 1'b0; rd_en = 1'b0; wr_en = 1'b0; dbg_en = 1'b0;
    wsize = '0; addr = '0; wdata = '0; dbg_addr = '0;
    model_reset();
    dbg_last = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_read_data", rdata, 32'h0);
    chk("reset_debug_data", dbg_data, 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    count_clear();
    for (int i = 0; i < 32; i++) debug_read(i);

    do_access(1, 0, COMPLETE_WORD, 7'h04, 32'hDEADBEEF, 0);
    do_access(0, 1, COMPLETE_WORD, 7'h04, 32'h0, 0);
    do_access(1, 0, BYTE_WORD,     7'h05, 32'h12345678, 0);
    do_access(0, 1, COMPLETE_WORD, 7'h04, 32'h0, 0);
    do_access(0, 1, BYTE_WORD,     7'h07, 32'h0, 0);
    do_access(0, 1, HALF_WORD,     7'h06, 32'h0, 0);
    do_access(1, 0, HALF_WORD,     7'h03, 32'hCAFEF00D, 0);
    do_access(0, 1, COMPLETE_WORD, 7'h00, 32'h0, 0);
    do_access(0, 1, COMPLETE_WORD, 7'h02, 32'h0, 0);
    do_access(0, 1, 3'd5,          7'h04, 32'h0, 0);
    do_access(0, 0, BYTE_WORD,     7'h04, 32'h0, 0);

    do_access(0, 1, COMPLETE_WORD, 7'h04, 32'h0, 1);
    wait_idle();
    chk("debug_hold_under_req", dbg_data, dbg_last);
    debug_read(1);

    for (int n = 0; n < 150; n++) begin
      t = $urandom_range(0, 9);
      sz = (t < 3) ? BYTE_WORD : (t < 6) ? HALF_WORD : (t < 9) ? COMPLETE_WORD
                                                       : 3'(3 + $urandom_range(0, 4));
      do_access($urandom_range(0, 1) == 1, 1'b1, sz, 7'($urandom_range(0, 127)),
                $urandom, $urandom_range(0, 3) == 0);
    end
    for (int n = 0; n < 8; n++) debug_read($urandom_range(0, 31));

    wait_idle();
    req = 1'b1; wr_en = 1'b1; wsize = COMPLETE_WORD; addr = 7'h08; wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req = 1'b0; wr_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("midreset_read_data", rdata, 32'h0);
    chk("midreset_done", 32'(done), 32'h0);
    rst = 1'b0;
    count_clear();
    debug_read(2);
    do_access(0, 1, COMPLETE_WORD, 7'h08, 32'h0, 0);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
